// File: rtl/ras_fifo_arb.sv
// ras_fifo_arb: front-end controller for the return-address spill FIFO.
// Round-robin arbitration of two producers onto the FIFO push port,
// occupancy tracking, valid/ready dequeue port, and FIFO reset sequencing
// after power-on and on pipeline flush.
module ras_fifo_arb #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 36,
    parameter bit BYPASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       req0_valid,
    input  logic [WIDTH-1:0]           req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [WIDTH-1:0]           req1_data,
    output logic                       req1_ready,
    output logic                       deq_valid,
    output logic [WIDTH-1:0]           deq_data,
    input  logic                       deq_ready,
    output logic                       fifo_rst,
    output logic                       fifo_push,
    output logic                       fifo_pop,
    output logic [WIDTH-1:0]           fifo_din,
    input  logic                       fifo_empty,
    input  logic [WIDTH-1:0]           fifo_dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       desync
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            rr_q, rr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            desync_q, desync_d;

    logic            open_w;
    logic            grant0, grant1;
    logic            push0, push1;

    // State register plus occupancy, round-robin pointer and sticky desync flag.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_INIT;
            rr_q     <= 1'b0;
            count_q  <= '0;
            desync_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            count_q  <= count_d;
            desync_q <= desync_d;
        end
    end

    // Next-state logic: INIT always runs one FIFO-reset cycle; FLUSH holds
    // the FIFO in reset for as long as flush stays high.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT:  state_d = S_RUN;
            S_RUN:   if (flush) state_d = S_FLUSH;
            S_FLUSH: if (!flush) state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // Handshake gating, arbitration, occupancy and desync detection.
    always_comb begin
        open_w     = (state_q == S_RUN) && !flush;
        full       = (count_q == DEPTH_C);

        // The requester not favoured by rr still wins when the other is idle.
        grant0     = req0_valid && (!req1_valid || (rr_q == 1'b0));
        grant1     = req1_valid && (!req0_valid || (rr_q == 1'b1));

        // Full blocks the push even when a pop happens in the same cycle, so
        // occupancy never depends on same-cycle read/write ordering at the FIFO.
        req0_ready = open_w && !full && grant0;
        req1_ready = open_w && !full && grant1;
        push0      = req0_ready && req0_valid;
        push1      = req1_ready && req1_valid;
        fifo_push  = push0 || push1;
        fifo_din   = grant1 ? req1_data : req0_data;

        // With bypass, an entry pushed into an empty FIFO is offered at once
        // through the FIFO's write-through dout.
        deq_valid  = open_w && ((count_q != '0) || (BYPASS && fifo_push));
        fifo_pop   = deq_valid && deq_ready;

        // Hand priority to the other requester after each accepted push.
        rr_d       = fifo_push ? push0 : rr_q;

        count_d    = count_q;
        if ((state_q != S_RUN) || flush) begin
            count_d = '0;
        end else if (fifo_push && !fifo_pop) begin
            count_d = count_q + 1'b1;
        end else if (fifo_pop && !fifo_push) begin
            count_d = count_q - 1'b1;
        end

        desync_d   = desync_q ||
                     ((state_q == S_RUN) && (fifo_empty != (count_q == '0)));
    end

    assign fifo_rst = (state_q != S_RUN);
    assign deq_data = fifo_dout;
    assign count    = count_q;
    assign desync   = desync_q;

endmodule

// File: tb/tb_ras_fifo_arb.sv
// Directed testbench for ras_fifo_arb. Two instances (BYPASS=1 and BYPASS=0,
// DEPTH=4) share all inputs; a small FIFO model answers the BYPASS=1 instance.
module tb_ras_fifo_arb;

    localparam int W = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          req0_valid, req1_valid, deq_ready;
    logic [W-1:0]  req0_data, req1_data;
    logic          force_ne;

    // Bypass instance outputs
    logic          r0_rdy, r1_rdy, dq_v, f_rst, f_push, f_pop, full_o, desync_o;
    logic [W-1:0]  dq_data, f_din;
    logic [2:0]    cnt;

    // Non-bypass instance outputs
    logic          nb_r0_rdy, nb_r1_rdy, nb_dq_v, nb_f_rst, nb_f_push, nb_f_pop;
    logic          nb_full, nb_desync;
    logic [W-1:0]  nb_dq_data, nb_f_din;
    logic [2:0]    nb_cnt;

    // FIFO model (for the bypass instance)
    logic [W-1:0]  mem [8];
    int            wp, rp, n;
    logic          fifo_empty;
    logic [W-1:0]  fifo_dout;

    int            tests_run = 0;
    int            tests_failed = 0;

    always #5 clk = ~clk;

    assign fifo_empty = force_ne ? 1'b0 : (n == 0);
    assign fifo_dout  = (n == 0) ? f_din : mem[rp];

    always @(posedge clk) begin
        if (f_rst) begin
            n  <= 0;
            wp <= 0;
            rp <= 0;
        end else if (!(f_push && f_pop && n == 0)) begin
            if (f_push) begin
                mem[wp] <= f_din;
                wp      <= (wp + 1) % 8;
            end
            if (f_pop) rp <= (rp + 1) % 8;
            n <= n + (f_push ? 1 : 0) - (f_pop ? 1 : 0);
        end
    end

    ras_fifo_arb #(.DEPTH(4), .WIDTH(W), .BYPASS(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(r0_rdy),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(r1_rdy),
        .deq_valid(dq_v), .deq_data(dq_data), .deq_ready(deq_ready),
        .fifo_rst(f_rst), .fifo_push(f_push), .fifo_pop(f_pop), .fifo_din(f_din),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .count(cnt), .full(full_o), .desync(desync_o)
    );

    ras_fifo_arb #(.DEPTH(4), .WIDTH(W), .BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(nb_r0_rdy),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(nb_r1_rdy),
        .deq_valid(nb_dq_v), .deq_data(nb_dq_data), .deq_ready(deq_ready),
        .fifo_rst(nb_f_rst), .fifo_push(nb_f_push), .fifo_pop(nb_f_pop), .fifo_din(nb_f_din),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .count(nb_cnt), .full(nb_full), .desync(nb_desync)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_d;
        rst = 1'b0; flush = 1'b0; force_ne = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; deq_ready = 1'b0;
        req0_data = '0; req1_data = '0;

        // Reset state
        step(); step();
        check("rst_fifo_rst", f_rst, 1);
        check("rst_readies", {r0_rdy, r1_rdy}, 0);
        check("rst_deq_valid", dq_v, 0);
        check("rst_push_pop", {f_push, f_pop}, 0);
        check("rst_count", cnt, 0);
        check("rst_full", full_o, 0);
        check("rst_desync", desync_o, 0);

        // Reset release: exactly one INIT cycle with fifo_rst high
        rst = 1'b1;
        #1;
        check("init_fifo_rst", f_rst, 1);
        step();
        check("run_fifo_rst", f_rst, 0);
        check("run_count", cnt, 0);
        check("run_deq_valid", dq_v, 0);
        step();
        check("idle_fifo_rst", f_rst, 0);
        check("idle_desync", desync_o, 0);

        // Both producers valid: grants alternate 0,1,0,1 until full
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_data = 36'hA00 + W'(i);
            req1_data = 36'hB00 + W'(i);
            #1;
            check("fill_r0_ready", r0_rdy, (i % 2 == 0));
            check("fill_r1_ready", r1_rdy, (i % 2 == 1));
            check("fill_din", f_din, (i % 2 == 0) ? 36'hA00 + i : 36'hB00 + i);
            check("fill_count", cnt, i);
            step();
        end
        check("full_flag", full_o, 1);
        check("full_count", cnt, 4);
        check("full_readies", {r0_rdy, r1_rdy}, 0);
        check("full_no_push", f_push, 0);

        // Drain in push order; a pop while full still blocks pushes
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            case (i)
                0: exp_d = 36'hA00;
                1: exp_d = 36'hB01;
                2: exp_d = 36'hA02;
                default: exp_d = 36'hB03;
            endcase
            if (i == 0) check("full_pop_blocks_push", {r0_rdy, r1_rdy, f_pop}, 3'b001);
            check("drain_valid", dq_v, 1);
            check("drain_data", dq_data, exp_d);
            check("drain_count", cnt, 4 - i);
            step();
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        #1;
        check("drained_count", cnt, 0);
        check("drained_valid", dq_v, 0);
        check("drained_pop", f_pop, 0);

        // Bypass: req1 into empty FIFO with deq_ready high
        req1_valid = 1'b1; req1_data = 36'h123456789;
        #1;
        check("byp_r1_ready", r1_rdy, 1);
        check("byp_deq_valid", dq_v, 1);
        check("byp_deq_data", dq_data, 36'h123456789);
        check("byp_pop", f_pop, 1);
        check("nobyp_deq_valid", nb_dq_v, 0);
        check("nobyp_r1_ready", nb_r1_rdy, 1);
        step();
        req1_valid = 1'b0; deq_ready = 1'b0;
        #1;
        check("byp_count", cnt, 0);
        check("nobyp_count", nb_cnt, 1);

        // Count to 3, then flush pulse while req0 is valid
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_data = 36'hC00 + W'(i);
            step();
        end
        #1;
        check("pre_flush_count", cnt, 3);
        flush = 1'b1;
        #1;
        check("flush_no_push", {r0_rdy, f_push}, 0);
        check("flush_no_deq", {dq_v, f_pop}, 0);
        step();
        flush = 1'b0; req0_valid = 1'b0; deq_ready = 1'b1;
        #1;
        check("flush_fifo_rst", f_rst, 1);
        check("flush_count", cnt, 0);
        check("flush_state_no_deq", dq_v, 0);
        step();
        check("post_flush_fifo_rst", f_rst, 0);
        check("post_flush_no_pop", {dq_v, f_pop}, 0);
        req0_valid = 1'b1; req0_data = 36'hD55;
        #1;
        check("post_flush_push", r0_rdy, 1);
        check("post_flush_deq", dq_data, 36'hD55);
        step();
        req0_valid = 1'b0; deq_ready = 1'b0;
        #1;
        check("post_flush_count", cnt, 0);

        // Desync: FIFO claims non-empty with count 0; sticky through a flush
        force_ne = 1'b1;
        #1;
        check("desync_not_yet", desync_o, 0);
        step();
        force_ne = 1'b0;
        check("desync_set", desync_o, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step(); step();
        check("desync_sticky", desync_o, 1);

        // Async reset mid-operation
        req0_valid = 1'b1; req0_data = 36'hE00;
        step();
        req0_valid = 1'b0;
        #1;
        check("pre_arst_count", cnt, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_count", cnt, 0);
        check("arst_desync", desync_o, 0);
        check("arst_fifo_rst", f_rst, 1);
        check("arst_deq_valid", dq_v, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
